// File: rtl/emds_pkg.sv
// Shared definitions for the encrypted-message link endpoint:
// character width, default message length, key derivation and
// character-slot addressing within a message bus.
package emds_pkg;

  localparam int CHAR_W        = 8;
  localparam int DEF_MSG_CHARS = 100;

  typedef logic [CHAR_W-1:0] char_t;

  // The 4-bit password is replicated into both nibbles to form the byte key.
  function automatic char_t make_key(input logic [3:0] password);
    return {password, password};
  endfunction

  // Char k of a [CHAR_W*msg_chars:1] bus occupies [slot_hi(k) -: CHAR_W];
  // char 0 sits in the most significant byte.
  function automatic int unsigned slot_hi(input int unsigned k,
                                          input int unsigned msg_chars);
    return CHAR_W * (msg_chars - k);
  endfunction

endpackage : emds_pkg

// File: rtl/emds_cipher.sv
// Byte cipher for the link: XOR with the key. The operation is its own
// inverse, so the same block serves for encrypt and decrypt.
module emds_cipher
  import emds_pkg::*;
(
  input  logic [CHAR_W-1:0] i_data,
  input  logic [CHAR_W-1:0] i_key,
  output logic [CHAR_W-1:0] o_data
);

  // Pure combinational XOR of the data byte with the key.
  always_comb begin
    o_data = i_data ^ i_key;
  end

endmodule : emds_cipher

// File: rtl/user.sv
// One endpoint of the encrypted-message link. After reset it streams its
// latched plaintext out one encrypted byte per clock while capturing the
// partner's ciphertext stream one edge behind, storing both the raw bytes
// and their decryption under the local password.
module user
  import emds_pkg::*;
#(
  parameter int MSG_CHARS = DEF_MSG_CHARS
)(
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [CHAR_W*MSG_CHARS:1] enter_text_here,
  input  logic [3:0]                password,
  output logic [CHAR_W-1:0]         out,
  input  logic [CHAR_W-1:0]         in,
  output logic [CHAR_W*MSG_CHARS:1] encrypted_message,
  output logic [CHAR_W*MSG_CHARS:1] receiving_message_to_file
);

  localparam int                 MSG_W   = CHAR_W * MSG_CHARS;
  localparam int                 IDX_W   = $clog2(MSG_CHARS + 1);
  localparam logic [IDX_W-1:0]   IDX_END = IDX_W'(MSG_CHARS);
  localparam logic [IDX_W-1:0]   IDX_ONE = IDX_W'(1);

  // Transmit side state
  logic [MSG_W:1]      r_tx_buf;
  logic                r_loaded;
  logic [IDX_W-1:0]    r_tx_idx;
  logic [CHAR_W-1:0]   r_out;

  // Receive side state
  logic                r_rx_armed;
  logic [IDX_W-1:0]    r_rx_idx;
  logic [MSG_W:1]      r_enc_msg;
  logic [MSG_W:1]      r_rx_msg;

  // Combinational helpers
  logic [CHAR_W-1:0]   w_key;
  logic                w_tx_active;
  logic                w_rx_active;
  logic [MSG_W:1]      w_tx_src;
  logic [IDX_W-1:0]    w_tx_sel;
  logic [CHAR_W-1:0]   w_tx_plain;
  logic [CHAR_W-1:0]   w_tx_enc;
  logic [CHAR_W-1:0]   w_rx_dec;

  // Key, activity flags and the plaintext char to send this edge. Before the
  // buffer is loaded (first edge) the char is taken straight from the input
  // bus; the select is clamped so the slot read never leaves the bus once
  // transmission is done.
  always_comb begin
    w_key       = make_key(password);
    w_tx_active = (r_tx_idx < IDX_END);
    w_rx_active = r_rx_armed && (r_rx_idx < IDX_END);
    w_tx_src    = r_loaded ? r_tx_buf : enter_text_here;
    w_tx_sel    = w_tx_active ? r_tx_idx : {IDX_W{1'b0}};
    w_tx_plain  = w_tx_src[slot_hi(32'(w_tx_sel), MSG_CHARS) -: CHAR_W];
  end

  emds_cipher u_tx_cipher (
    .i_data (w_tx_plain),
    .i_key  (w_key),
    .o_data (w_tx_enc)
  );

  emds_cipher u_rx_cipher (
    .i_data (in),
    .i_key  (w_key),
    .o_data (w_rx_dec)
  );

  // Latch the outgoing text once after reset and stream it out byte by byte.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_tx_buf   <= {MSG_W{1'b0}};
      r_loaded   <= 1'b0;
      r_tx_idx   <= {IDX_W{1'b0}};
      r_out      <= {CHAR_W{1'b0}};
    end else begin
      if (!r_loaded) begin
        r_tx_buf <= enter_text_here;
        r_loaded <= 1'b1;
      end else begin
        r_tx_buf <= r_tx_buf;
        r_loaded <= r_loaded;
      end
      if (w_tx_active) begin
        r_out    <= w_tx_enc;
        r_tx_idx <= r_tx_idx + IDX_ONE;
      end else begin
        r_out    <= {CHAR_W{1'b0}};
        r_tx_idx <= r_tx_idx;
      end
    end
  end

  // Arm reception once transmission starts (partner's first byte arrives
  // one edge later), then capture raw and decrypted bytes slot by slot.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_rx_armed <= 1'b0;
      r_rx_idx   <= {IDX_W{1'b0}};
      r_enc_msg  <= {MSG_W{1'b0}};
      r_rx_msg   <= {MSG_W{1'b0}};
    end else begin
      if (w_tx_active) begin
        r_rx_armed <= 1'b1;
      end else begin
        r_rx_armed <= r_rx_armed;
      end
      if (w_rx_active) begin
        r_enc_msg[slot_hi(32'(r_rx_idx), MSG_CHARS) -: CHAR_W] <= in;
        r_rx_msg[slot_hi(32'(r_rx_idx), MSG_CHARS) -: CHAR_W]  <= w_rx_dec;
        r_rx_idx <= r_rx_idx + IDX_ONE;
      end else begin
        r_rx_idx <= r_rx_idx;
      end
    end
  end

  assign out                       = r_out;
  assign encrypted_message         = r_enc_msg;
  assign receiving_message_to_file = r_rx_msg;

endmodule : user

// File: tb/tb_user.sv
// Directed bench: two cross-coupled endpoints exchanging messages, with
// checks on reset state, byte timing, loopback contents, input freeze,
// password mismatch and reset in the middle of a transfer.
module tb_user;

  localparam int N = 100;
  localparam int W = 8 * N;

  logic          clock;
  logic          reset_n;
  logic [W:1]    text1, text2;
  logic [3:0]    pw1, pw2;
  logic [7:0]    out1, out2;
  logic [W:1]    enc1, enc2, rx1, rx2;
  logic [W:1]    t1_orig, exp_v;

  int n_checks;
  int n_fail;

  user #(.MSG_CHARS(N)) u1 (
    .clock                     (clock),
    .reset_n                   (reset_n),
    .enter_text_here           (text1),
    .password                  (pw1),
    .out                       (out1),
    .in                        (out2),
    .encrypted_message         (enc1),
    .receiving_message_to_file (rx1)
  );

  user #(.MSG_CHARS(N)) u2 (
    .clock                     (clock),
    .reset_n                   (reset_n),
    .enter_text_here           (text2),
    .password                  (pw2),
    .out                       (out2),
    .in                        (out1),
    .encrypted_message         (enc2),
    .receiving_message_to_file (rx2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [W:1] act, input logic [W:1] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One active edge, then settle at the falling edge for sampling/driving.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  function automatic logic [W:1] xor_msg(input logic [W:1] m, input logic [7:0] k);
    logic [W:1] r;
    for (int i = 0; i < N; i++) r[8*(N-i) -: 8] = m[8*(N-i) -: 8] ^ k;
    return r;
  endfunction

  function automatic logic [7:0] slot(input logic [W:1] m, input int k);
    return m[8*(N-k) -: 8];
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    pw1      = 4'b0101;
    pw2      = 4'b0101;
    text1    = "HELLO";
    text1[W -: 8] = 8'h41;            // char 0 = 'A', chars 95..99 = "HELLO"
    text2    = "WORLD";
    t1_orig  = text1;

    // Reset state
    tick(2);
    check_eq("reset_out1", {{(W-8){1'b0}}, out1}, {W{1'b0}});
    check_eq("reset_enc2", enc2, {W{1'b0}});
    check_eq("reset_rx1",  rx1,  {W{1'b0}});

    // Phase 1: loopback, byte timing, input freeze
    reset_n = 1'b1;
    tick(1);                                      // E0
    check_eq("e0_out1_A", {{(W-8){1'b0}}, out1}, {{(W-8){1'b0}}, 8'h14});
    for (int i = 0; i < N; i++) text1[8*(N-i) -: 8] = 8'h5A;   // must be ignored
    tick(1);                                      // E1
    check_eq("e1_out1_zero_char", {{(W-8){1'b0}}, out1}, {{(W-8){1'b0}}, 8'h55});
    check_eq("e1_enc2_slot0", {{(W-8){1'b0}}, slot(enc2, 0)}, {{(W-8){1'b0}}, 8'h14});
    tick(98);                                     // E99
    check_eq("e99_out1_O", {{(W-8){1'b0}}, out1}, {{(W-8){1'b0}}, 8'h1A});
    check_eq("e99_rx2_slot99_empty", {{(W-8){1'b0}}, slot(rx2, 99)}, {W{1'b0}});
    tick(1);                                      // E100
    check_eq("e100_out1_idle", {{(W-8){1'b0}}, out1}, {W{1'b0}});
    check_eq("e100_out2_idle", {{(W-8){1'b0}}, out2}, {W{1'b0}});
    check_eq("loop_rx2", rx2, t1_orig);
    check_eq("loop_rx1", rx1, text2);
    exp_v = xor_msg(t1_orig, 8'h55);
    check_eq("loop_enc2", enc2, exp_v);
    check_eq("loop_enc2_H", {{(W-8){1'b0}}, slot(enc2, 95)}, {{(W-8){1'b0}}, 8'h1D});
    check_eq("loop_enc2_pad", {{(W-8){1'b0}}, slot(enc2, 1)}, {{(W-8){1'b0}}, 8'h55});
    tick(3);
    check_eq("hold_rx2", rx2, t1_orig);
    check_eq("hold_enc1", enc1, xor_msg(text2, 8'h55));

    // Phase 2: password mismatch plus reset mid-transfer
    reset_n = 1'b0;
    text1   = t1_orig;
    pw2     = 4'b0011;
    tick(1);
    reset_n = 1'b1;
    tick(1);                                      // E0
    check_eq("p2_e0_out2", {{(W-8){1'b0}}, out2}, {{(W-8){1'b0}}, 8'h33});
    tick(50);                                     // through E50
    check_eq("mid_rx2_nonzero", {{(W-8){1'b0}}, slot(rx2, 0)}, {{(W-8){1'b0}}, 8'h27});
    reset_n = 1'b0;
    tick(1);
    check_eq("midrst_out1", {{(W-8){1'b0}}, out1}, {W{1'b0}});
    check_eq("midrst_out2", {{(W-8){1'b0}}, out2}, {W{1'b0}});
    check_eq("midrst_enc2", enc2, {W{1'b0}});
    check_eq("midrst_rx2",  rx2,  {W{1'b0}});
    check_eq("midrst_rx1",  rx1,  {W{1'b0}});
    reset_n = 1'b1;
    tick(1);
    check_eq("restart_out1", {{(W-8){1'b0}}, out1}, {{(W-8){1'b0}}, 8'h14});
    tick(100);
    check_eq("mm_enc2_slot0", {{(W-8){1'b0}}, slot(enc2, 0)}, {{(W-8){1'b0}}, 8'h14});
    check_eq("mm_rx2_slot0",  {{(W-8){1'b0}}, slot(rx2, 0)},  {{(W-8){1'b0}}, 8'h27});
    check_eq("mm_enc2", enc2, xor_msg(t1_orig, 8'h55));
    check_eq("mm_rx2",  rx2,  xor_msg(t1_orig, 8'h66));
    check_eq("mm_rx1",  rx1,  xor_msg(text2, 8'h66));
    check_eq("mm_out1_idle", {{(W-8){1'b0}}, out1}, {W{1'b0}});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_user

// File: doc/user.md
# user

Endpoint of the encrypted-message link (EMDS): one instance per user, and two instances are cross-coupled (`out` of one drives `in` of the other). After reset, the block sends its 100-character plaintext message one encrypted byte per clock. At the same time it receives the partner's encrypted byte stream, keeps the raw ciphertext, and decrypts it with the local 4-bit password into a received-message buffer.

## Interface
- `MSG_CHARS`, default 100: message length in 8-bit characters; all message buses are `8*MSG_CHARS` bits, declared `[8*MSG_CHARS:1]`.

Ports:
- `clock` in 1: single clock, rising-edge.
- `reset_n` in 1: reset is synchronous and active-low.
- `enter_text_here` in 8*MSG_CHARS: outgoing plaintext; char 0 is bits [8*MSG_CHARS : 8*MSG_CHARS-7].
- `password` in 4: local key nibble.
- `out` out 8: encrypted byte to partner.
- `in` in 8: encrypted byte from partner.
- `encrypted_message` out 8*MSG_CHARS: received ciphertext, same char layout.
- `receiving_message_to_file` out 8*MSG_CHARS: decrypted received text, same layout.

## Operation
- **Key.** `key = {password, password}` (8 bits).
- **Cipher.** `enc(b) = b ^ key` and `dec(c) = c ^ key` (involution).
- **Registered outputs.** All outputs are registered.
- **Counters.** `tx_idx` runs 0..MSG_CHARS. `rx_idx` runs 0..MSG_CHARS.
- **Control flags.** `rx_armed` and `loaded`.
- **Reset (`reset_n` = 0 at an edge):**
  - `out` = 0.
  - `encrypted_message` = 0 and `receiving_message_to_file` = 0.
  - `tx_idx` = 0, `rx_idx` = 0, `rx_armed` = 0, `loaded` = 0.
- **Load.** On the first active edge, `enter_text_here` is latched into an internal tx buffer (`loaded` = 1). Later changes are ignored until the next reset.
- **TX, at each active edge with `tx_idx` < MSG_CHARS:**
  - `out` <= enc(tx_char[`tx_idx`]) and `tx_idx`++.
  - On the first edge the char comes directly from `enter_text_here`.
  - `rx_armed` <= 1.
- **TX done (`tx_idx` == MSG_CHARS).** `out` <= 0, idle.
- **RX, at each edge with `rx_armed` = 1 and `rx_idx` < MSG_CHARS:**
  - slot `rx_idx` of `encrypted_message` <= `in`.
  - slot `rx_idx` of `receiving_message_to_file` <= dec(`in`).
  - `rx_idx`++.
- **Completion.** At `rx_idx` == MSG_CHARS both buffers hold their contents until reset.
- **Password timing.** `password` is used combinationally at each edge. A change mid-transfer affects only the bytes processed from then on.
- **Zero bytes.** Zero (padding) bytes are transferred like any other: 0x00 goes out as `key` and decrypts back to 0x00.
- **Framing.** There is no framing or handshake. Partners must leave reset on the same edge. Byte k is valid on `in` exactly one edge after it was driven.

## Timing
- Edge numbering: E0 is the first edge with `reset_n` = 1.
- At E_k (k < MSG_CHARS), `out` becomes enc(char k).
- At E_{k+1}, received byte k is captured into slot k.
- Last tx byte: E_{MSG_CHARS-1}. `out` returns to 0 at E_{MSG_CHARS}.
- RX complete at E_{MSG_CHARS}: 101 edges after reset release for MSG_CHARS = 100.
- **Reset mid-transfer.** The next edge with `reset_n` = 0 clears everything. The transfer restarts from char 0 after release.

## Structure
- **Shared package `emds_pkg`:**
  - `CHAR_W` = 8 and default `MSG_CHARS` = 100.
  - function `make_key(password)`.
  - slot-index helpers: char k maps to bit range [8*(MSG_CHARS-k) -: 8].
- **Sub-module `emds_cipher`:** combinational byte XOR with the key. Instantiated twice, once for tx encrypt and once for rx decrypt.
- **Top `user`:** counters, tx buffer, rx buffers.

## Test plan
- **Loopback.** Connect two instances cross-wise, both with `password` = 4'b0101. Send "HELLO" (right-justified, leading zero chars) and "WORLD". → After 101 edges, each `receiving_message_to_file` equals the partner's text. Each `encrypted_message` char equals text ^ 0x55 (e.g. 'H' 0x48 → 0x1D; 0x00 → 0x55).
- **Byte timing.** Char 0 = 'A' (0x41), `password` 4'b0101. → `out` = 0x14 right after E0. Char 1 appears after E1. `out` = 0x00 after E100.
- **Password mismatch.** User1 `password` 4'b0101, user2 4'b0011, user1 sends 'A'. → User2 decrypts 0x14 ^ 0x33 = 0x27 ("'"). Its raw `encrypted_message` slot is 0x14.
- **Reset mid-transfer.** Pulse `reset_n` low for one edge at E50. → All outputs read 0 after that edge. Retransmission restarts at char 0, and a complete message is received 101 edges after release.
- **Input freeze.** Change `enter_text_here` after E0. → Transmitted bytes still reflect the text latched at E0.
